// File: rtl/led_level_display_if.sv
// led_level_display_if: level input and LED outputs of the display stage.
// master drives the level; slave is the display.
interface led_level_display_if;
    logic [5:0] level_in;
    logic [5:0] led_n;
    logic       wrap_pulse;

    modport master (
        output level_in,
        input  led_n,
        input  wrap_pulse
    );

    modport slave (
        input  level_in,
        output led_n,
        output wrap_pulse
    );
endinterface

// File: rtl/led_level_display.sv
// led_level_display: 6-bit level -> fractional PWM bar on active-low LEDs.
// Optional macro LED_GAMMA_EN selects a gamma duty table instead of linear.
module led_level_display #(
    parameter int PRESCALE     = 1024,
    parameter int FLASH_FRAMES = 64
) (
    input  logic               clk,
    input  logic               rstn,
    led_level_display_if.slave bus
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
    localparam logic [FW-1:0] F_LAST = FW'(FLASH_FRAMES - 1);

    typedef enum logic {
        NORMAL,
        FLASH
    } state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [2:0]    phase;
    logic [5:0]    shadow;
    logic [5:0]    prev;
    logic          prev_valid;
    logic [FW-1:0] fcnt;

    logic       tick;
    logic       frame_end;
    logic       wrap;
    logic [5:0] bar_n;

    function automatic logic [2:0] duty(input logic [2:0] x);
`ifdef LED_GAMMA_EN
        logic [2:0] d;
        unique case (x)
            3'd0:    d = 3'd0;
            3'd1:    d = 3'd1;
            3'd2:    d = 3'd1;
            3'd3:    d = 3'd2;
            3'd4:    d = 3'd3;
            3'd5:    d = 3'd4;
            3'd6:    d = 3'd6;
            default: d = 3'd7;
        endcase
        return d;
`else
        return x;
`endif
    endfunction

    assign tick      = (presc == P_LAST);
    assign frame_end = tick && (phase == 3'd7);
    assign wrap      = prev_valid &&
                       (((prev == 6'd63) && (bus.level_in == 6'd0)) ||
                        ((prev == 6'd0) && (bus.level_in == 6'd63)));

    // Bar pattern for the current shadow level and PWM phase
    always_comb begin
        logic [2:0] full;
        logic [2:0] d;
        full  = shadow[5:3];
        d     = duty(shadow[2:0]);
        bar_n = '1;
        for (int i = 0; i < 6; i++) begin
            if ((3'(i) < full) || ((3'(i) == full) && (phase < d)))
                bar_n[i] = 1'b0;
        end
    end

    // PWM timebase, frame-aligned level shadow and wrap history
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            presc      <= '0;
            phase      <= '0;
            shadow     <= '0;
            prev       <= '0;
            prev_valid <= 1'b0;
        end else begin
            presc      <= tick ? '0 : presc + 1'b1;
            prev       <= bus.level_in;
            prev_valid <= 1'b1;
            if (tick)
                phase <= phase + 3'd1;
            if (frame_end)
                shadow <= bus.level_in;
        end
    end

    // Display mode FSM with flash timer and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= NORMAL;
            fcnt           <= '0;
            bus.led_n      <= 6'b111111;
            bus.wrap_pulse <= 1'b0;
        end else begin
            bus.wrap_pulse <= wrap;
            bus.led_n      <= (state == FLASH) ? 6'b000000 : bar_n;
            unique case (state)
                NORMAL: begin
                    if (wrap) begin
                        state <= FLASH;
                        fcnt  <= '0;
                    end
                end
                FLASH: begin
                    if (wrap) begin
                        fcnt <= '0;
                    end else if (frame_end) begin
                        if (fcnt == F_LAST)
                            state <= NORMAL;
                        else
                            fcnt <= fcnt + 1'b1;
                    end
                end
                default: state <= NORMAL;
            endcase
        end
    end
endmodule

// File: tb/tb_led_level_display.sv
// tb_led_level_display: directed checks of bar mapping, shadowing and flash.
// PRESCALE=4 gives 32-cycle frames; FLASH_FRAMES=2.
module tb_led_level_display;
    logic clk;
    logic rstn;
    int   k;
    int   checks;
    int   failures;

    led_level_display_if bus ();

    led_level_display #(
        .PRESCALE    (4),
        .FLASH_FRAMES(2)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (k=%0d)", tag, got, exp, k);
        end
    endtask

    task automatic goto(input int target);
        while (k < target) begin
            @(posedge clk);
            k++;
        end
        #1;
    endtask

    int lit2;
    int bad_lo;
    int bad_hi;
    int exp_lit;

    initial begin
        checks   = 0;
        failures = 0;
        k        = 0;
        rstn     = 1'b0;
        bus.level_in = 6'd63;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_led", 32'(bus.led_n), 32'h3f);
        chk("rst_wrap", 32'(bus.wrap_pulse), 32'h0);
        @(negedge clk);
        rstn = 1'b1;

        goto(1);
        chk("no_wrap_1", 32'(bus.wrap_pulse), 32'h0);
        goto(2);
        chk("no_wrap_2", 32'(bus.wrap_pulse), 32'h0);
        goto(32);
        chk("pre_frame", 32'(bus.led_n), 32'h3f);
        goto(33);
        chk("full_bar", 32'(bus.led_n), 32'h00);

        bus.level_in = 6'd19;
        goto(64);
        chk("old_shadow", 32'(bus.led_n), 32'h00);
        lit2   = 0;
        bad_lo = 0;
        bad_hi = 0;
        for (int c = 65; c <= 96; c++) begin
            goto(c);
            if (c == 65)
                chk("lvl19_ph0", 32'(bus.led_n), 32'h38);
            if (bus.led_n[2] == 1'b0)
                lit2++;
            if (bus.led_n[1:0] != 2'b00)
                bad_lo++;
            if (bus.led_n[5:3] != 3'b111)
                bad_hi++;
        end
`ifdef LED_GAMMA_EN
        exp_lit = 8;
`else
        exp_lit = 12;
`endif
        chk("duty_led2", 32'(lit2), 32'(exp_lit));
        chk("full_lo", 32'(bad_lo), 32'd0);
        chk("off_hi", 32'(bad_hi), 32'd0);

        goto(100);
        bus.level_in = 6'd8;
        goto(129);
        chk("lvl8", 32'(bus.led_n), 32'h3e);
        goto(140);
        bus.level_in = 6'd40;
        goto(150);
        chk("mid_frame", 32'(bus.led_n), 32'h3e);
        goto(160);
        chk("at_bound", 32'(bus.led_n), 32'h3e);
        goto(161);
        chk("lvl40", 32'(bus.led_n), 32'h20);

        bus.level_in = 6'd63;
        goto(170);
        chk("pre_wrap", 32'(bus.wrap_pulse), 32'h0);
        bus.level_in = 6'd0;
        goto(171);
        chk("wrap_hi", 32'(bus.wrap_pulse), 32'h1);
        goto(172);
        chk("wrap_lo", 32'(bus.wrap_pulse), 32'h0);
        chk("flash_on", 32'(bus.led_n), 32'h00);
        goto(224);
        chk("flash_end", 32'(bus.led_n), 32'h00);
        goto(225);
        chk("flash_off", 32'(bus.led_n), 32'h3f);

        goto(230);
        bus.level_in = 6'd63;
        goto(231);
        chk("wrap2_hi", 32'(bus.wrap_pulse), 32'h1);
        goto(232);
        chk("wrap2_lo", 32'(bus.wrap_pulse), 32'h0);
        goto(260);
        bus.level_in = 6'd0;
        goto(261);
        chk("wrap3_hi", 32'(bus.wrap_pulse), 32'h1);
        goto(262);
        chk("wrap3_lo", 32'(bus.wrap_pulse), 32'h0);
        goto(289);
        chk("ext_289", 32'(bus.led_n), 32'h00);
        goto(320);
        chk("ext_320", 32'(bus.led_n), 32'h00);
        goto(321);
        chk("ext_done", 32'(bus.led_n), 32'h3f);

        goto(330);
        bus.level_in = 6'd63;
        goto(340);
        chk("pre_rst", 32'(bus.led_n), 32'h00);
        rstn = 1'b0;
        #2;
        chk("arst_led", 32'(bus.led_n), 32'h3f);
        chk("arst_wrap", 32'(bus.wrap_pulse), 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("post_rst", 32'(bus.led_n), 32'h3f);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
